// File: rtl/isqrt16_if.sv
// Start/busy/done handshake bundle for the integer square-root unit.
// The requester drives start and x; the unit returns res, busy and done.
interface isqrt16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] res;
  logic             busy;
  logic             done;

  modport master (
    output start, x,
    input  res, busy, done
  );

  modport slave (
    input  start, x,
    output res, busy, done
  );
endinterface

// File: rtl/isqrt16.sv
// Sequential floor(sqrt(x)) unit, restoring shift/subtract form.
// Produces one root bit per clock over WIDTH/2 iterations.
module isqrt16 #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  isqrt16_if.slave    bus
);
  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(H + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] w_op_nx;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_nx;
  logic [H+1:0]     r_rem;
  logic [H+1:0]     w_rem_nx;
  logic [H+1:0]     w_rem_sh;
  logic [H+1:0]     w_trial;
  logic [H-1:0]     r_root;
  logic [H-1:0]     w_root_nx;
  logic [H-1:0]     w_root_it;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nx;
  logic             r_busy;
  logic             w_busy_nx;
  logic             r_done;
  logic             w_done_nx;
  logic             w_ge;

  // Before the last shift the remainder fits in H bits,
  // so the two bits dropped by the shift are always zero.
  assign w_rem_sh  = (r_rem << 2)
                   | (H + 2)'(r_op[WIDTH-1 -: 2]);
  assign w_trial   = {r_root, 2'b01};
  assign w_ge      = (w_rem_sh >= w_trial);
  assign w_root_it = {r_root[H-2:0], w_ge};

  always_comb begin
    w_state_nx = r_state;
    w_op_nx    = r_op;
    w_res_nx   = r_res;
    w_rem_nx   = r_rem;
    w_root_nx  = r_root;
    w_cnt_nx   = r_cnt;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_op_nx    = bus.x;
          w_rem_nx   = '0;
          w_root_nx  = '0;
          w_cnt_nx   = CW'(H);
          w_busy_nx  = 1'b1;
          w_state_nx = RUN;
        end
      end
      RUN: begin
        w_op_nx   = r_op << 2;
        w_rem_nx  = w_ge ? (w_rem_sh - w_trial)
                         : w_rem_sh;
        w_root_nx = w_root_it;
        w_cnt_nx  = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_res_nx   = {{(WIDTH-H){1'b0}}, w_root_it};
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_res   <= '0;
      r_rem   <= '0;
      r_root  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_op    <= w_op_nx;
      r_res   <= w_res_nx;
      r_rem   <= w_rem_nx;
      r_root  <= w_root_nx;
      r_cnt   <= w_cnt_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  assign bus.res  = r_res;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_isqrt16.sv
// Self-checking bench for isqrt16: vector table, handshake,
// mid-run reset and a back-to-back sweep against a scoreboard.
module tb_isqrt16;
  localparam int W = 16;

  typedef struct {
    logic [15:0] x;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  isqrt16_if #(.WIDTH(W)) bus ();

  isqrt16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          n_done = 0;
  int          cyc = 0;
  int          last_done = -1;
  bit          sweep_on = 1'b0;
  logic [15:0] sb[$];
  logic [15:0] mon_exp;

  always @(posedge clk) cyc++;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return 16'(r);
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        mon_exp = sb.pop_front();
        check("res", 32'(bus.res), 32'(mon_exp));
        check("res_upper", 32'(bus.res[15:8]), 32'd0);
      end
      if (sweep_on && last_done >= 0)
        check("done_spacing", cyc - last_done, 9);
      last_done = cyc;
    end
  end

  task automatic run_one(logic [15:0] x, logic [15:0] exp);
    int lat;
    int bc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = x;
    sb.push_back(exp);
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    bc  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
      if (bus.busy === 1'b1) bc++;
    end
    if (lat == 0) sb.delete();
    check("latency", lat, 9);
    check("busy_cycles", bc, 8);
    @(negedge clk);
    check("done_width", 32'(bus.done), 32'd0);
  endtask

  vec_t tbl[9];
  int   xs[$];

  initial begin
    int nd;
    int found;
    int idx;
    int guard;

    tbl[0] = '{16'h0000, 16'h0000};
    tbl[1] = '{16'h0001, 16'h0001};
    tbl[2] = '{16'hFFFF, 16'h00FF};
    tbl[3] = '{16'h0010, 16'h0004};
    tbl[4] = '{16'h000F, 16'h0003};
    tbl[5] = '{16'hFE01, 16'h00FF};
    tbl[6] = '{16'hFE00, 16'h00FE};
    tbl[7] = '{16'h4000, 16'h0080};
    tbl[8] = '{16'h3FFF, 16'h007F};

    bus.start = 1'b0;
    bus.x     = '0;
    reset     = 1'b1;
    #1;
    check("rst_res", 32'(bus.res), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    #20;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      run_one(tbl[i].x, tbl[i].exp);

    repeat (5) @(negedge clk);
    check("res_hold", 32'(bus.res), 32'h007F);

    // start while busy is ignored; x changes mid-run are ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = 16'h0064;
    sb.push_back(16'h000A);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("res_kept_in_run", 32'(bus.res), 32'h007F);
    bus.start = 1'b1;
    bus.x     = 16'h0009;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.x = 16'hFFFF;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        found = 1;
        break;
      end
    end
    if (found == 0) sb.delete();
    check("busy_done_seen", found, 1);
    @(negedge clk);
    nd = n_done;
    repeat (12) @(negedge clk);
    check("ignored_start", n_done, nd);

    // reset at iteration 4 aborts without a done pulse
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = 16'hFFFF;
    sb.push_back(16'h00FF);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_res", 32'(bus.res), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    sb.delete();
    nd = n_done;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done", n_done, nd);
    run_one(16'h0051, 16'h0009);

    // back-to-back sweep with start held high
    for (int k = 0; k < 256; k++) begin
      xs.push_back(k * k);
      if (k > 0) xs.push_back(k * k - 1);
    end
    xs.push_back(16'hFFFF);
    for (int i = 0; i < 1024; i++)
      xs.push_back(i * 64 + (i * 37) % 64);
    sweep_on  = 1'b1;
    last_done = -1;
    idx       = 0;
    guard     = 0;
    while (idx < xs.size() && guard < xs.size() * 9 + 100) begin
      @(negedge clk);
      guard++;
      if (bus.busy === 1'b0) begin
        bus.start = 1'b1;
        bus.x     = 16'(xs[idx]);
        sb.push_back(model(xs[idx]));
        idx++;
      end
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("sweep_issued", idx, xs.size());
    for (int i = 0; i < 30 && sb.size() != 0; i++)
      @(negedge clk);
    check("sweep_drain", sb.size(), 0);
    sweep_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
